// File: rtl/life_pkg.sv
// Shared types and constants for the Conway generation sequencer.
package life_pkg;

    localparam int unsigned DefRows  = 4;
    localparam int unsigned DefCols  = 16;
    localparam int unsigned DefAddrW = 2;
    localparam int unsigned CntW     = 4;

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    function automatic logic [CntW-1:0] count_ones8(logic [7:0] n);
        logic [CntW-1:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + CntW'(n[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/life_gen_sequencer_if.sv
// Selector port of the cell array memory as seen by the generation sequencer.
interface life_gen_sequencer_if
    import life_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned COLS   = DefCols
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [COLS-1:0]   mem_wdata;
    logic [COLS-1:0]   mem_rdata;

    modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/life_row_next.sv
// Next-generation value of one row from its vertical neighbours.
// Column borders are dead unless LIFE_WRAP_EN is defined (toroidal).
module life_row_next
    import life_pkg::*;
#(
    parameter int unsigned COLS = DefCols
) (
    input  logic [COLS-1:0] above_i,
    input  logic [COLS-1:0] cur_i,
    input  logic [COLS-1:0] below_i,
    output logic [COLS-1:0] next_o
);

    // Bit 0 of each extended row is column -1, bit COLS+1 is column COLS.
    logic [COLS+1:0] a_ext;
    logic [COLS+1:0] c_ext;
    logic [COLS+1:0] b_ext;

`ifdef LIFE_WRAP_EN
    assign a_ext = {above_i[0], above_i, above_i[COLS-1]};
    assign c_ext = {cur_i[0], cur_i, cur_i[COLS-1]};
    assign b_ext = {below_i[0], below_i, below_i[COLS-1]};
`else
    assign a_ext = {1'b0, above_i, 1'b0};
    assign c_ext = {1'b0, cur_i, 1'b0};
    assign b_ext = {1'b0, below_i, 1'b0};
`endif

    logic [CntW-1:0] cnt;

    always_comb begin
        next_o = '0;
        cnt    = '0;
        for (int c = 0; c < COLS; c++) begin
            cnt = count_ones8({a_ext[c +: 3], c_ext[c + 2], c_ext[c], b_ext[c +: 3]});
            next_o[c] = (cnt == CntW'(3)) | (cur_i[c] & (cnt == CntW'(2)));
        end
    end

endmodule

// File: rtl/life_gen_sequencer.sv
// Reads the whole cell array into a shadow buffer, then writes back one Conway
// generation row by row. LIFE_WRAP_EN selects a toroidal grid instead of dead borders.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int unsigned ROWS   = DefRows,
    parameter int unsigned COLS   = DefCols,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic        busy,
    output logic        done,
    output logic        stable,
    output logic [15:0] gen_count,
    life_gen_sequencer_if.master mem
);

    localparam int unsigned       RowsM1   = ROWS - 1;
    localparam logic [ADDR_W-1:0] LastRow  = RowsM1[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   LoadLast = ROWS[ADDR_W:0];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              differ_q, differ_d;
    logic              stable_q, stable_d;
    logic [15:0]       gen_q, gen_d;
    logic [COLS-1:0]   shadow_q [ROWS];
    logic [COLS-1:0]   shadow_d [ROWS];

    logic [ADDR_W-1:0] row;
    logic [ADDR_W:0]   ld_idx;
    logic [COLS-1:0]   above_row, cur_row, below_row, next_row;
    logic              diff_now;

    // Vertical neighbour selection; column handling lives in life_row_next.
    always_comb begin
        row     = cnt_q[ADDR_W-1:0];
        cur_row = shadow_q[row];
`ifdef LIFE_WRAP_EN
        above_row = (row == '0) ? shadow_q[ROWS-1] : shadow_q[row - 1'b1];
        below_row = (row == LastRow) ? shadow_q[0] : shadow_q[row + 1'b1];
`else
        above_row = (row == '0) ? '0 : shadow_q[row - 1'b1];
        below_row = (row == LastRow) ? '0 : shadow_q[row + 1'b1];
`endif
    end

    life_row_next #(
        .COLS (COLS)
    ) u_row_next (
        .above_i (above_row),
        .cur_i   (cur_row),
        .below_i (below_row),
        .next_o  (next_row)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        differ_d      = differ_q;
        stable_d      = stable_q;
        gen_d         = gen_q;
        shadow_d      = shadow_q;
        mem.mem_addr  = '0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = '0;
        ld_idx        = cnt_q - 1'b1;
        diff_now      = differ_q | (next_row != cur_row);

        unique case (state_q)
            StIdle: begin
                if (step) begin
                    state_d  = StLoad;
                    cnt_d    = '0;
                    differ_d = 1'b0;
                end
            end
            StLoad: begin
                // Data for the address issued last cycle arrives now.
                if (cnt_q != LoadLast) mem.mem_addr = row;
                if (cnt_q != '0) shadow_d[ld_idx[ADDR_W-1:0]] = mem.mem_rdata;
                if (cnt_q == LoadLast) begin
                    state_d = StWrite;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrite: begin
                mem.mem_addr  = row;
                mem.mem_we    = 1'b1;
                mem.mem_wdata = next_row;
                differ_d      = diff_now;
                if (row == LastRow) begin
                    state_d  = StDone;
                    cnt_d    = '0;
                    stable_d = ~diff_now;
                    gen_d    = gen_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            differ_q <= 1'b0;
            stable_q <= 1'b0;
            gen_q    <= '0;
            shadow_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            differ_q <= differ_d;
            stable_q <= stable_d;
            gen_q    <= gen_d;
            shadow_q <= shadow_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign stable    = stable_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Self-checking bench for life_gen_sequencer with a behavioural cell array memory.
module tb_life_gen_sequencer;

    typedef logic [3:0][15:0] grid_t;

    typedef struct {
        string name;
        grid_t init;
        grid_t exp_next;
        logic  exp_stable;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic        busy, done, stable;
    logic [15:0] gen_count;

    life_gen_sequencer_if mif ();

    life_gen_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .stable    (stable),
        .gen_count (gen_count),
        .mem       (mif.master)
    );

    always #5 clk = ~clk;

    // Cell array memory: address registered at the edge, data readable in the next cycle.
    grid_t       mem;
    grid_t       pl_grid;
    logic        pl_en = 1'b0;
    logic [1:0]  raddr_q;
    int          we_cnt = 0;

    always @(posedge clk) begin
        raddr_q <= mif.mem_addr;
        if (pl_en) mem <= pl_grid;
        else if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
        if (mif.mem_we) we_cnt <= we_cnt + 1;
    end

    assign mif.mem_rdata = mem[raddr_q];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic grid_t mk(logic [15:0] r0, logic [15:0] r1, logic [15:0] r2,
                                 logic [15:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    // Reference: straight from the cell rule on a 4x16 grid.
    function automatic grid_t life_ref(grid_t g);
        grid_t n;
        int    cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_WRAP_EN
                            rr = (rr + 4) % 4;
                            cc = (cc + 16) % 16;
                            cnt += int'(g[rr][cc]);
`else
                            if (rr >= 0 && rr < 4 && cc >= 0 && cc < 16) cnt += int'(g[rr][cc]);
`endif
                        end
                    end
                end
                n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        end
        return n;
    endfunction

    task automatic preload(input grid_t g);
        pl_grid = g;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    // One generation; extra[k] drives step during cycle k after acceptance.
    task automatic run_gen(input grid_t init, input logic [31:0] extra, output grid_t res);
        grid_t       model;
        int          we0, done_at, busy_bad;
        logic [15:0] gc0;
        preload(init);
        model   = life_ref(init);
        gc0     = gen_count;
        we0     = we_cnt;
        done_at = -1;
        busy_bad = 0;
        step = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            step = extra[k];
            if (done) begin
                done_at = k;
                check("gen_count_at_done", 64'(gen_count), 64'(gc0 + 16'd1));
                check("stable_at_done", 64'(stable), 64'(model == init));
                break;
            end
            if (!busy) busy_bad++;
            tick();
        end
        step = 1'b0;
        check("done_latency", 64'(done_at), 64'(10));
        check("busy_during_gen", 64'(busy_bad), 64'(0));
        tick();
        check("done_one_cycle", 64'(done), 64'(0));
        check("busy_after_done", 64'(busy), 64'(0));
        check("mem_vs_model", mem, model);
        check("write_cycles", 64'(we_cnt - we0), 64'(4));
        res = mem;
    endtask

    vec_t  vecs [6];
    grid_t res, g;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"blinker", mk(16'h0000, 16'h0380, 16'h0000, 16'h0000),
                    mk(16'h0100, 16'h0100, 16'h0100, 16'h0000), 1'b0};
        vecs[1] = '{"blinker_back", mk(16'h0100, 16'h0100, 16'h0100, 16'h0000),
                    mk(16'h0000, 16'h0380, 16'h0000, 16'h0000), 1'b0};
        vecs[2] = '{"block", mk(16'h0000, 16'h0180, 16'h0180, 16'h0000),
                    mk(16'h0000, 16'h0180, 16'h0180, 16'h0000), 1'b1};
        vecs[3] = '{"empty", '0, '0, 1'b1};
`ifdef LIFE_WRAP_EN
        vecs[4] = '{"edge_blinker", mk(16'h0000, 16'h8003, 16'h0000, 16'h0000),
                    mk(16'h0001, 16'h0001, 16'h0001, 16'h0000), 1'b0};
        vecs[5] = '{"full_row0", mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000),
                    mk(16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF), 1'b0};
`else
        vecs[4] = '{"edge_blinker", mk(16'h0000, 16'h8003, 16'h0000, 16'h0000),
                    '0, 1'b0};
        vecs[5] = '{"full_row0", mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000),
                    mk(16'h7FFE, 16'h7FFE, 16'h0000, 16'h0000), 1'b0};
`endif

        reset = 1'b1;
        step  = 1'b0;
        tick();
        step  = 1'b1;  // reset wins over step
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_stable", 64'(stable), 64'(0));
        check("rst_gen_count", 64'(gen_count), 64'(0));
        check("rst_mem_addr", 64'(mif.mem_addr), 64'(0));
        check("rst_mem_we", 64'(mif.mem_we), 64'(0));
        check("rst_mem_wdata", 64'(mif.mem_wdata), 64'(0));
        step  = 1'b0;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_gen(vecs[i].init, 32'h0, res);
            check({"tbl_next_", vecs[i].name}, res, vecs[i].exp_next);
            check({"tbl_stable_", vecs[i].name}, 64'(stable), 64'(vecs[i].exp_stable));
        end
        check("gen_count_after_table", 64'(gen_count), 64'(6));

        // Steps during LOAD and WRITE are dropped.
        run_gen(vecs[0].init, 32'h0000_0088, res);
        tick();
        tick();
        check("busy_step_idle", 64'(busy), 64'(0));
        check("busy_step_gen_count", 64'(gen_count), 64'(7));

        for (int i = 0; i < 30; i++) begin
            g = {$urandom, $urandom};
            run_gen(g, $urandom & 32'h0000_07FE, res);
        end

        // Reset mid-LOAD leaves memory untouched.
        g = mk(16'h0000, 16'h0380, 16'h0000, 16'h0000);
        preload(g);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_load_busy", 64'(busy), 64'(0));
        tick();
        check("rst_load_mem", mem, g);

        // Reset during the second write cycle: rows 0..1 new, rows 2..3 old.
        preload(g);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int k = 1; k < 7; k++) tick();
        check("rst_write_we_before", 64'(mif.mem_we), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_write_we_after", 64'(mif.mem_we), 64'(0));
        check("rst_write_busy", 64'(busy), 64'(0));
        check("rst_write_gen_count", 64'(gen_count), 64'(0));
        tick();
        check("rst_write_mem", mem, mk(16'h0100, 16'h0100, 16'h0000, 16'h0000));

        for (int i = 0; i < 100; i++) begin
            run_gen('0, 32'h0, res);
            check("empty_stable", 64'(stable), 64'(1));
        end
        check("empty_gen_count", 64'(gen_count), 64'(100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
